// File: rtl/fsl_matvec_fx_pkg.sv
// Shared definitions for the fixed-point matrix-vector FSL peripheral:
// command codes, controller states and width helpers.
package matvec_pkg;

    localparam logic [1:0] CMD_LOAD_M = 2'b00;
    localparam logic [1:0] CMD_VECTOR = 2'b01;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_M,
        LOAD_V,
        MAC,
        OUT
    } state_t;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

    // Wide enough that DIM full-precision products can never overflow the sum.
    function automatic int acc_w(input int data_w, input int dim);
        return 2 * data_w + clog2(dim);
    endfunction

endpackage

// File: rtl/fsl_matvec_fx_if.sv
// FSL slave (command/data in) and master (results out) link bundle.
interface fsl_matvec_fx_if #(
    parameter int DATA_W = 32
);
    logic              FSL_S_Read;
    logic [DATA_W-1:0] FSL_S_Data;
    logic              FSL_S_Control;
    logic              FSL_S_Exists;
    logic              FSL_M_Write;
    logic [DATA_W-1:0] FSL_M_Data;
    logic              FSL_M_Control;
    logic              FSL_M_Full;

    // The peripheral side.
    modport slave (
        output FSL_S_Read,
        input  FSL_S_Data,
        input  FSL_S_Control,
        input  FSL_S_Exists,
        output FSL_M_Write,
        output FSL_M_Data,
        output FSL_M_Control,
        input  FSL_M_Full
    );

    // The processor / FIFO side.
    modport master (
        input  FSL_S_Read,
        output FSL_S_Data,
        output FSL_S_Control,
        output FSL_S_Exists,
        input  FSL_M_Write,
        input  FSL_M_Data,
        input  FSL_M_Control,
        output FSL_M_Full
    );
endinterface

// File: rtl/fsl_matvec_fx_mac.sv
// Signed multiply-accumulate with per-row restart, plus the round-half-up
// and saturate stage that turns the accumulator into one result word.
module matvec_mac #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int ACC_W  = 66
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     first,
    input  logic signed [DATA_W-1:0] a,
    input  logic signed [DATA_W-1:0] b,
    output logic signed [DATA_W-1:0] result
);

    localparam logic [ACC_W:0] HALF =
        {{(ACC_W + 1 - FRAC_W){1'b0}}, 1'b1, {(FRAC_W - 1){1'b0}}};
    localparam logic signed [ACC_W:0] SAT_MAX =
        {{(ACC_W + 2 - DATA_W){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN =
        {{(ACC_W + 2 - DATA_W){1'b1}}, {(DATA_W - 1){1'b0}}};

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc;
    logic signed [ACC_W-1:0]    acc_next;
    logic signed [ACC_W:0]      rounded;
    logic signed [ACC_W:0]      shifted;

    assign prod     = a * b;
    assign acc_next = (first ? '0 : acc) + {{(ACC_W - 2*DATA_W){prod[2*DATA_W-1]}}, prod};

    // Result reflects the sum including this cycle's product, so the last
    // column's output can be captured on the same edge that ends the row.
    assign rounded  = {acc_next[ACC_W-1], acc_next} + HALF;
    assign shifted  = rounded >>> FRAC_W;

    always_comb begin
        result = shifted[DATA_W-1:0];
        if (shifted > SAT_MAX) begin
            result = SAT_MAX[DATA_W-1:0];
        end else if (shifted < SAT_MIN) begin
            result = SAT_MIN[DATA_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/fsl_matvec_fx.sv
// Fixed-point DIM x DIM matrix-vector multiplier on an FSL slave/master pair:
// persistent matrix, streamed vectors, one saturated result per row.
module fsl_matvec_fx
    import matvec_pkg::*;
#(
    parameter int DIM    = 4,
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16
) (
    input  logic             FSL_Clk,
    input  logic             FSL_Rst,
    fsl_matvec_fx_if.slave   fsl
);

    localparam int ACC_W = acc_w(DATA_W, DIM);
    localparam int CW    = clog2(DIM);
    localparam int IW    = clog2(DIM * DIM);

    state_t            state;
    state_t            cmd_state;
    logic [IW-1:0]     ld_cnt;
    logic [IW-1:0]     m_idx;
    logic [CW-1:0]     row;
    logic [CW-1:0]     col;
    logic [DATA_W-1:0] mat [DIM*DIM];
    logic [DATA_W-1:0] vec [DIM];
    logic              pop;
    logic [DATA_W-1:0] mac_result;

    assign pop             = fsl.FSL_S_Exists && (state inside {IDLE, LOAD_M, LOAD_V});
    assign fsl.FSL_S_Read  = pop;
    assign fsl.FSL_M_Write = (state == OUT) && !fsl.FSL_M_Full;
    assign m_idx           = IW'(row) * IW'(DIM) + IW'(col);

    always_comb begin
        cmd_state = IDLE;
        case (fsl.FSL_S_Data[1:0])
            CMD_LOAD_M: cmd_state = LOAD_M;
            CMD_VECTOR: cmd_state = LOAD_V;
            default:    cmd_state = IDLE;
        endcase
    end

    matvec_mac #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W),
        .ACC_W  (ACC_W)
    ) u_mac (
        .clk    (FSL_Clk),
        .rst_n  (FSL_Rst),
        .en     (state == MAC),
        .first  (col == '0),
        .a      (mat[m_idx]),
        .b      (vec[col]),
        .result (mac_result)
    );

    // A command word always wins: it aborts any load in progress and
    // restarts from its own opcode, leaving already-written entries intact.
    always_ff @(posedge FSL_Clk or negedge FSL_Rst) begin
        if (!FSL_Rst) begin
            state             <= IDLE;
            ld_cnt            <= '0;
            row               <= '0;
            col               <= '0;
            fsl.FSL_M_Data    <= '0;
            fsl.FSL_M_Control <= 1'b0;
            for (int i = 0; i < DIM*DIM; i++) begin
                mat[i] <= '0;
            end
            for (int i = 0; i < DIM; i++) begin
                vec[i] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (pop && fsl.FSL_S_Control) begin
                        state  <= cmd_state;
                        ld_cnt <= '0;
                    end
                end
                LOAD_M: begin
                    if (pop && fsl.FSL_S_Control) begin
                        state  <= cmd_state;
                        ld_cnt <= '0;
                    end else if (pop) begin
                        mat[ld_cnt] <= fsl.FSL_S_Data;
                        if (ld_cnt == IW'(DIM*DIM - 1)) begin
                            state <= IDLE;
                        end else begin
                            ld_cnt <= ld_cnt + IW'(1);
                        end
                    end
                end
                LOAD_V: begin
                    if (pop && fsl.FSL_S_Control) begin
                        state  <= cmd_state;
                        ld_cnt <= '0;
                    end else if (pop) begin
                        vec[ld_cnt[CW-1:0]] <= fsl.FSL_S_Data;
                        if (ld_cnt == IW'(DIM - 1)) begin
                            state <= MAC;
                            row   <= '0;
                            col   <= '0;
                        end else begin
                            ld_cnt <= ld_cnt + IW'(1);
                        end
                    end
                end
                MAC: begin
                    if (col == CW'(DIM - 1)) begin
                        fsl.FSL_M_Data    <= mac_result;
                        fsl.FSL_M_Control <= (row == CW'(DIM - 1));
                        col               <= '0;
                        state             <= OUT;
                    end else begin
                        col <= col + CW'(1);
                    end
                end
                OUT: begin
                    if (!fsl.FSL_M_Full) begin
                        if (row == CW'(DIM - 1)) begin
                            state <= IDLE;
                        end else begin
                            row   <= row + CW'(1);
                            state <= MAC;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fsl_matvec_fx.sv
// Directed self-checking bench for fsl_matvec_fx with DIM=4, Q16.16 operands.
module tb_fsl_matvec_fx;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fsl_matvec_fx_if #(.DATA_W(32)) bus ();

    fsl_matvec_fx #(
        .DIM    (4),
        .DATA_W (32),
        .FRAC_W (16)
    ) dut (
        .FSL_Clk (clk),
        .FSL_Rst (rst_n),
        .fsl     (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic        ctrl;
        int          cyc;
    } out_t;

    out_t outq[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   cycle = 0;
    int   last_read_cycle = 0;
    int   cyc[4];

    logic [31:0] m_ident[16] = '{32'h00010000, 0, 0, 0,
                                 0, 32'h00010000, 0, 0,
                                 0, 0, 32'h00010000, 0,
                                 0, 0, 0, 32'h00010000};
    logic [31:0] m_gen[16]   = '{32'h00010000, 32'h00010000, 0, 0,
                                 0, 32'h00020000, 0, 0,
                                 32'h00008000, 0, 0, 32'hFFFF0000,
                                 0, 0, 0, 0};
    logic [31:0] m_round[16] = '{32'h00000001, 0, 0, 0, 0, 0, 0, 0,
                                 0, 0, 0, 0, 0, 0, 0, 0};
    logic [31:0] m_pos[16]   = '{default: 32'h7FFF0000};
    logic [31:0] m_neg[16]   = '{default: 32'h80000000};

    logic [31:0] v_id[4]    = '{32'h00010000, 32'h00020000, 32'hFFFD0000, 32'h00008000};
    logic [31:0] v_two[4]   = '{32'h00030000, 32'hFFFF8000, 32'h00000000, 32'h00010000};
    logic [31:0] v_bp[4]    = '{32'h00050000, 32'hFFFFFFFF, 32'h00000010, 32'h7FFF0000};
    logic [31:0] v_a[4]     = '{32'h00010000, 32'h00020000, 32'h00030000, 32'h00040000};
    logic [31:0] v_b[4]     = '{32'h00020000, 32'h00000000, 32'h00000000, 32'h00010000};
    logic [31:0] v_ones[4]  = '{default: 32'h00010000};
    logic [31:0] v_half[4]  = '{32'h00008000, 0, 0, 0};

    logic [31:0] e_a[4]     = '{32'h00030000, 32'h00040000, 32'hFFFC8000, 32'h00000000};
    logic [31:0] e_b[4]     = '{32'h00020000, 32'h00000000, 32'h00000000, 32'h00000000};
    logic [31:0] e_round[4] = '{32'h00000001, 0, 0, 0};
    logic [31:0] e_pos[4]   = '{default: 32'h7FFFFFFF};
    logic [31:0] e_neg[4]   = '{default: 32'h80000000};
    logic [31:0] e_zero[4]  = '{default: 32'h00000000};

    always @(posedge clk) cycle <= cycle + 1;

    always @(negedge clk) begin
        if (rst_n && bus.FSL_M_Write) begin
            outq.push_back('{bus.FSL_M_Data, bus.FSL_M_Control, cycle});
        end
    end

    task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Presents one word and holds it until the DUT pops it.
    task automatic applyStimulus(input logic ctrl, input logic [31:0] data);
        bit done;
        done = 1'b0;
        bus.FSL_S_Data    = data;
        bus.FSL_S_Control = ctrl;
        bus.FSL_S_Exists  = 1'b1;
        for (int k = 0; k < 100 && !done; k++) begin
            @(negedge clk);
            if (bus.FSL_S_Read) begin
                done = 1'b1;
                last_read_cycle = cycle;
            end
        end
        @(posedge clk);
        #1;
        bus.FSL_S_Exists = 1'b0;
        if (!done) begin
            n_checks++;
            n_fail++;
            $error("[TB] FAIL read_timeout observed=no_pop expected=pop data=%h", data);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] exp_data,
                               input logic exp_ctrl, output int out_cyc);
        out_t o;
        out_cyc = 0;
        for (int k = 0; k < 200 && outq.size() == 0; k++) begin
            @(posedge clk);
        end
        if (outq.size() == 0) begin
            n_checks++;
            n_fail++;
            $error("[TB] FAIL %s_timeout observed=no_write expected=%h", tag, exp_data);
        end else begin
            o = outq.pop_front();
            out_cyc = o.cyc;
            checkValue({tag, "_data"}, o.data, exp_data);
            checkValue({tag, "_ctrl"}, {31'd0, o.ctrl}, {31'd0, exp_ctrl});
        end
    endtask

    task automatic load_matrix(input logic [31:0] m[16]);
        applyStimulus(1'b1, 32'h0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, m[i]);
    endtask

    task automatic send_vector(input logic [31:0] v[4]);
        applyStimulus(1'b1, 32'h1);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, v[i]);
    endtask

    task automatic check_vector(input string tag, input logic [31:0] e[4], output int c[4]);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("%s_r%0d", tag, i), e[i], i == 3, c[i]);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.FSL_S_Exists  = 1'b0;
        bus.FSL_S_Data    = '0;
        bus.FSL_S_Control = 1'b0;
        bus.FSL_M_Full    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkValue("rst_s_read", {31'd0, bus.FSL_S_Read}, 32'd0);
        checkValue("rst_m_write", {31'd0, bus.FSL_M_Write}, 32'd0);
        checkValue("rst_m_data", bus.FSL_M_Data, 32'd0);
        checkValue("rst_m_ctrl", {31'd0, bus.FSL_M_Control}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Stray data word and an unknown opcode in IDLE: popped, no output.
        applyStimulus(1'b0, 32'h12345678);
        applyStimulus(1'b1, 32'h00000003);
        repeat (20) @(posedge clk);
        checkValue("stray_no_out", 32'(outq.size()), 32'd0);

        load_matrix(m_ident);
        send_vector(v_id);
        check_vector("ident", v_id, cyc);
        checkValue("ident_latency", 32'(cyc[0] - last_read_cycle), 32'd5);
        checkValue("ident_spacing", 32'(cyc[1] - cyc[0]), 32'd5);

        send_vector(v_two);
        check_vector("persist", v_two, cyc);

        // Partial vector is discarded by a new command word.
        applyStimulus(1'b1, 32'h1);
        applyStimulus(1'b0, 32'hAAAA0000);
        applyStimulus(1'b0, 32'h55550000);
        send_vector(v_a);
        check_vector("abort", v_a, cyc);
        repeat (10) @(posedge clk);
        checkValue("abort_no_extra", 32'(outq.size()), 32'd0);

        // Back-pressure at the first OUT, with a data word waiting on the slave side.
        send_vector(v_bp);
        bus.FSL_M_Full    = 1'b1;
        bus.FSL_S_Data    = 32'hDEAD0000;
        bus.FSL_S_Control = 1'b0;
        bus.FSL_S_Exists  = 1'b1;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checkValue($sformatf("bp_write%0d", i), {31'd0, bus.FSL_M_Write}, 32'd0);
            checkValue($sformatf("bp_data%0d", i), bus.FSL_M_Data, v_bp[0]);
            checkValue($sformatf("bp_sread%0d", i), {31'd0, bus.FSL_S_Read}, 32'd0);
        end
        @(posedge clk);
        #1;
        bus.FSL_S_Exists = 1'b0;
        bus.FSL_M_Full   = 1'b0;
        check_vector("bp", v_bp, cyc);
        repeat (10) @(posedge clk);
        checkValue("bp_no_extra", 32'(outq.size()), 32'd0);

        load_matrix(m_gen);
        send_vector(v_a);
        check_vector("gen_a", e_a, cyc);
        send_vector(v_b);
        check_vector("gen_b", e_b, cyc);

        load_matrix(m_round);
        send_vector(v_half);
        check_vector("round", e_round, cyc);

        load_matrix(m_pos);
        send_vector(v_ones);
        check_vector("sat_pos", e_pos, cyc);

        load_matrix(m_neg);
        send_vector(v_ones);
        check_vector("sat_neg", e_neg, cyc);

        // Reset while in MAC: work discarded, outputs and matrix cleared.
        send_vector(v_ones);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkValue("mrst_m_write", {31'd0, bus.FSL_M_Write}, 32'd0);
        checkValue("mrst_m_data", bus.FSL_M_Data, 32'd0);
        checkValue("mrst_m_ctrl", {31'd0, bus.FSL_M_Control}, 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        checkValue("mrst_no_out", 32'(outq.size()), 32'd0);
        send_vector(v_a);
        check_vector("mrst_zero", e_zero, cyc);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fsl_matvec_fx.md
# fsl_matvec_fx

Parametrised fixed-point matrix-vector multiplier on an FSL slave/master pair, successor to the fixed 4x4 float32 matrixmult peripheral. It holds a persistent DIM x DIM coefficient matrix loaded by command, then streams any number of DIM-element vectors through it. Each vector produces DIM saturated fixed-point results. It sits between the MicroBlaze FSL link and the pixel pipeline.

## Interface
- DIM, 4: matrix dimension and vector length (2..16).
- DATA_W, 32: word width, signed two's complement.
- FRAC_W, 16: fractional bits of all operands and results (Q(DATA_W-FRAC_W).FRAC_W).
- FSL_Clk  in  1  sole clock, rising edge.
- FSL_Rst  in  1  reset, asynchronous, active-low.
- FSL_S_Read  out  1  pops the current slave word.
- FSL_S_Data  in  DATA_W  slave word.
- FSL_S_Control  in  1  1 = command word, 0 = data word.
- FSL_S_Exists  in  1  slave word available.
- FSL_M_Write  out  1  pushes FSL_M_Data.
- FSL_M_Data  out  DATA_W  result word.
- FSL_M_Control  out  1  1 on the last result of a vector.
- FSL_M_Full  in  1  master FIFO full.

## Operation
- Command word (Control=1), S_Data[1:0]:
  - 00 LOAD_M: the next DIM*DIM data words are the matrix, row-major.
  - 01 VECTOR: the next DIM data words are v[0..DIM-1].
  - Other codes: popped and ignored.
- States:
  - IDLE: data words are popped and discarded; command words dispatch to LOAD_M or LOAD_V.
  - LOAD_M: after DIM*DIM words, go to IDLE.
  - LOAD_V: after DIM words, go to MAC with row r=0.
  - MAC: DIM cycles, acc += M[r][c]*v[c] for c=0..DIM-1; then go to OUT.
  - OUT: hold until the write completes; r<DIM-1 gives r+1 and MAC, otherwise IDLE.
- FSL_S_Read = FSL_S_Exists && state in {IDLE, LOAD_M, LOAD_V}. This is combinational, so at most one word is accepted per cycle.
- Command word during LOAD_M/LOAD_V: it aborts the load and dispatches as new.
  - Matrix entries already written stay written.
  - The partial vector is discarded.
- Matrix registers persist across vectors and reset to 0. VECTOR with no prior LOAD_M yields all-zero results.
- Arithmetic:
  - Full-precision signed products.
  - Accumulator ACC_W = 2*DATA_W + clog2(DIM) bits, cleared at the start of each row.
  - Result = (acc + 2^(FRAC_W-1)) >>> FRAC_W, which is round-half-up, then saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].

## Timing
- Reset values: FSL_S_Read=0 (state IDLE), FSL_M_Write=0, FSL_M_Data=0, FSL_M_Control=0, acc=0, matrix=0. Reset mid-operation discards all work and clears the matrix.
- Result timing:
  - FSL_M_Data and FSL_M_Control are registered on the edge that leaves MAC.
  - FSL_M_Write = (state==OUT) && !FSL_M_Full.
  - The write completes on the edge where FSL_M_Write=1.
- Latency: first FSL_M_Write is high DIM+1 cycles after the cycle in which the last vector word was read, given FSL_M_Full=0.
- Throughput: (DIM+1) cycles per result. A vector takes DIM*(DIM+1) cycles plus the load.
- Back-pressure: while FSL_M_Full=1 in OUT, FSL_M_Write is 0 and FSL_M_Data/Control are held stable. No slave words are popped during MAC or OUT.
- FSL_M_Control=1 only alongside the result for row DIM-1.

## Structure
- Package matvec_pkg holds:
  - the command encodings CMD_LOAD_M and CMD_VECTOR;
  - the state enum {IDLE, LOAD_M, LOAD_V, MAC, OUT};
  - the ACC_W and clog2 helper functions.
- Sub-module matvec_mac (DATA_W, FRAC_W, ACC_W): multiply-accumulate register with clear, and the round/saturate output stage.
- The top level holds the FSM, the matrix/vector register files and the row/column counters.

## Test plan
- Identity: LOAD_M with an identity matrix (0x00010000 on the diagonal), then VECTOR [0x00010000, 0x00020000, 0xFFFD0000, 0x00008000]. Required outputs are the same four words in order, with M_Control only on the 4th, and the first write DIM+1=5 cycles after the last read.
- Saturation: all M=0x7FFF0000, v all 0x00010000 -> four outputs 0x7FFFFFFF. All M=0x80000000 -> four outputs 0x80000000.
- Rounding: M[0][0]=0x00000001, all other entries 0, v0=0x00008000 -> row0 = 0x00000001, rows 1-3 = 0.
- Back-pressure: hold M_Full=1 for 5 cycles at the first OUT. Required: no write and stable data while full, then all 4 words delivered in order with no loss or duplication.
- Persistence and abort:
  - Two consecutive VECTOR commands after one LOAD_M both produce correct results.
  - A command word mid-LOAD_V discards the partial vector; the next VECTOR computes correctly.
  - A stray data word in IDLE is popped with no output.
- Reset: drive FSL_Rst low during MAC -> M_Write=0 immediately. A subsequent VECTOR with no LOAD_M outputs four 0x00000000.
